// File: rtl/hwpe_instr_seq.sv
// hwpe_instr_seq
//   Sequencer that issues the HWPE custom-0 instruction stream in hardware.
//   Stream order: reset, wcfg, 4x wfad, ROWS*PES accumulator clears (wacc),
//   matrix, then one read-back phase per output tile (racc or relu).
//   Every instruction is one 96-bit beat {cmd_instr, cmd_rs1, cmd_rs2}.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               1-cycle pulse, latches cfg_*; ignored while busy
//   cfg_*               sequence configuration, sampled on start
//   cmd_valid/cmd_ready beat handshake towards the HWPE command port
//   cmd_instr/rs1/rs2   beat payload
//   busy                sequence in progress (PREP through DONE)
//   done                1-cycle pulse after the last beat is accepted
//   dbg_state           current FSM state
// Handshake: a beat transfers when cmd_valid && cmd_ready on a rising edge.
//   While cmd_valid is high and cmd_ready is low the payload holds stable,
//   and cmd_valid is never withdrawn before the beat transfers (except on reset).
module hwpe_instr_seq #(
  parameter int unsigned ROWS             = 8,
  parameter int unsigned PES              = 16,
  parameter logic [31:0] FMEM_ADDR2_START = 32'h0,
  parameter logic [6:0]  OPCODE           = 7'h0B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  cfg_kernel_size,
  input  logic [1:0]  cfg_data_type,
  input  logic        cfg_layer_type,
  input  logic        cfg_kernel_333,
  input  logic [4:0]  cfg_acc_shift,
  input  logic [9:0]  cfg_k_count,
  input  logic [15:0] cfg_h_count,
  input  logic [15:0] cfg_w_count,
  input  logic [15:0] cfg_h_stride,
  input  logic [15:0] cfg_w_stride,
  input  logic [15:0] cfg_ch_count,
  input  logic [15:0] cfg_w_offset,
  input  logic        cfg_relu,
  input  logic [31:0] cfg_relu_waddr,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [31:0] cmd_instr,
  output logic [31:0] cmd_rs1,
  output logic [31:0] cmd_rs2,
  output logic        busy,
  output logic        done,
  output logic [3:0]  dbg_state
);

  localparam logic [2:0] ROW_LAST = 3'(ROWS - 1);
  localparam logic [4:0] PE_LAST  = 5'(PES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PREP, S_RST, S_WCFG, S_WFAD, S_WACC, S_MATRIX, S_DRAIN, S_DONE
  } state_t;

  state_t state_q, state_d;

  // latched configuration
  logic [3:0]  ksize_q;
  logic [1:0]  dtype_q;
  logic        layer_q, k333_q, relu_q;
  logic [4:0]  shift_q;
  logic [9:0]  k_cnt_q;
  logic [15:0] h_cnt_q, w_cnt_q, h_str_q, w_str_q, ch_cnt_q, w_off_q;
  logic [31:0] waddr_q;

  // sequencing state
  logic [31:0] hc_q;    // h_count * h_stride
  logic [31:0] acc_q;   // j * hc, built by repeated addition across wfad beats
  logic [1:0]  wfad_q;
  logic [2:0]  row_q;
  logic [4:0]  pe_q;
  logic [9:0]  k_q;
  logic [15:0] h_q, w_q;

  logic xfer, row_last, pe_last, h_last, w_last, k_last, tile_last, beat_last, any_zero;
  logic [4:0] row_f;

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2f,
                                      input logic [4:0] rs1f, input logic [2:0] x,
                                      input logic [4:0] rdf);
    return {f7, rs2f, rs1f, x, rdf, OPCODE};
  endfunction

  assign xfer      = cmd_valid && cmd_ready;
  assign row_last  = (row_q == ROW_LAST);
  assign pe_last   = (pe_q == PE_LAST);
  assign h_last    = (h_q == h_cnt_q - 16'd1);
  assign w_last    = (w_q == w_cnt_q - 16'd1);
  assign k_last    = (k_q == k_cnt_q - 10'd1);
  assign tile_last = k_last && w_last && h_last;
  // relu tiles are one beat per row; racc tiles walk every PE of every row
  assign beat_last = relu_q ? row_last : (row_last && pe_last);
  assign any_zero  = (k_cnt_q == '0) || (h_cnt_q == '0) || (w_cnt_q == '0);
  // the closing beat of every tile but the final one carries the tile-end marker
  assign row_f     = (beat_last && !tile_last) ? {2'b10, row_q} : {2'b00, row_q};
  assign dbg_state = state_q;

  always_comb begin
    state_d   = state_q;
    cmd_valid = 1'b0;
    cmd_instr = '0;
    cmd_rs1   = '0;
    cmd_rs2   = '0;
    busy      = (state_q != S_IDLE);
    done      = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_PREP;
      S_PREP: state_d = S_RST;
      S_RST: begin
        cmd_valid = 1'b1;
        cmd_instr = enc(7'd64, 5'd0, 5'd0, 3'b000, 5'd0);
        if (xfer) state_d = S_WCFG;
      end
      S_WCFG: begin
        cmd_valid = 1'b1;
        cmd_instr = enc(7'd2, 5'd0, 5'd0, 3'b011, 5'd0);
        cmd_rs1   = {w_off_q, ch_cnt_q};
        cmd_rs2   = {9'b0, k_cnt_q, shift_q, k333_q, layer_q, dtype_q, ksize_q};
        if (xfer) state_d = S_WFAD;
      end
      S_WFAD: begin
        cmd_valid = 1'b1;
        cmd_instr = enc(7'd1, 5'd0, 5'd0, 3'b011, {2'b00, wfad_q, 1'b0});
        // 3x3x3 kernels only use the first two slot pairs
        if (!(k333_q && wfad_q[1])) begin
          cmd_rs1 = acc_q;
          cmd_rs2 = FMEM_ADDR2_START + acc_q;
        end
        if (xfer && wfad_q == 2'd3) state_d = S_WACC;
      end
      S_WACC: begin
        cmd_valid = 1'b1;
        cmd_instr = enc(7'd8, pe_q, 5'd0, 3'b010, {2'b00, row_q});
        if (xfer && row_last && pe_last) state_d = S_MATRIX;
      end
      S_MATRIX: begin
        cmd_valid = 1'b1;
        cmd_instr = enc(7'd4, 5'd0, 5'd0, 3'b011, 5'd0);
        cmd_rs1   = {w_cnt_q, h_cnt_q};
        cmd_rs2   = {w_str_q, h_str_q};
        if (xfer) state_d = any_zero ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        cmd_valid = 1'b1;
        if (relu_q) begin
          cmd_instr = enc(7'd32, row_f, 5'd0, 3'b010, 5'd0);
          cmd_rs1   = waddr_q;
        end else begin
          cmd_instr = enc(7'd16, pe_q, row_f, 3'b100, 5'd0);
        end
        if (xfer && beat_last && tile_last) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ksize_q  <= '0;
      dtype_q  <= '0;
      layer_q  <= 1'b0;
      k333_q   <= 1'b0;
      relu_q   <= 1'b0;
      shift_q  <= '0;
      k_cnt_q  <= '0;
      h_cnt_q  <= '0;
      w_cnt_q  <= '0;
      h_str_q  <= '0;
      w_str_q  <= '0;
      ch_cnt_q <= '0;
      w_off_q  <= '0;
      waddr_q  <= '0;
      hc_q     <= '0;
      acc_q    <= '0;
      wfad_q   <= '0;
      row_q    <= '0;
      pe_q     <= '0;
      k_q      <= '0;
      h_q      <= '0;
      w_q      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (start) begin
          ksize_q  <= cfg_kernel_size;
          dtype_q  <= cfg_data_type;
          layer_q  <= cfg_layer_type;
          k333_q   <= cfg_kernel_333;
          relu_q   <= cfg_relu;
          shift_q  <= cfg_acc_shift;
          k_cnt_q  <= cfg_k_count;
          h_cnt_q  <= cfg_h_count;
          w_cnt_q  <= cfg_w_count;
          h_str_q  <= cfg_h_stride;
          w_str_q  <= cfg_w_stride;
          ch_cnt_q <= cfg_ch_count;
          w_off_q  <= cfg_w_offset;
          waddr_q  <= cfg_relu_waddr;
        end
        S_PREP: begin
          hc_q   <= 32'(h_cnt_q) * 32'(h_str_q);
          acc_q  <= '0;
          wfad_q <= '0;
          row_q  <= '0;
          pe_q   <= '0;
        end
        S_WFAD: if (xfer) begin
          wfad_q <= wfad_q + 2'd1;
          acc_q  <= acc_q + hc_q;
        end
        S_WACC: if (xfer) begin
          if (pe_last) begin
            pe_q  <= '0;
            row_q <= row_last ? 3'd0 : row_q + 3'd1;
          end else begin
            pe_q <= pe_q + 5'd1;
          end
        end
        S_MATRIX: if (xfer) begin
          row_q <= '0;
          pe_q  <= '0;
          k_q   <= '0;
          h_q   <= '0;
          w_q   <= '0;
        end
        S_DRAIN: if (xfer) begin
          if (beat_last) begin
            row_q <= '0;
            pe_q  <= '0;
            // tile order: K outer, W middle, H inner
            if (h_last) begin
              h_q <= '0;
              if (w_last) begin
                w_q <= '0;
                k_q <= k_q + 10'd1;
              end else begin
                w_q <= w_q + 16'd1;
              end
            end else begin
              h_q <= h_q + 16'd1;
            end
          end else if (relu_q || pe_last) begin
            pe_q  <= '0;
            row_q <= row_q + 3'd1;
          end else begin
            pe_q <= pe_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
